// File: rtl/spi_fl_line_fetch_pkg.sv
// Shared constants for the SPI flash line fetcher: default widths, FSM encodings
// and helpers that derive the index/tag widths from the line geometry.
package spi_fl_line_fetch_pkg;

  localparam int DEF_ADDR_W     = 24;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LINE_WORDS = 4;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RESP      = 3'd4;

  function automatic int idxWidth(input int lineWords);
    return $clog2(lineWords);
  endfunction

  // Byte offset bits [1:0] and the word index sit below the tag.
  function automatic int tagWidth(input int addrW, input int lineWords);
    return addrW - $clog2(lineWords) - 2;
  endfunction

endpackage

// File: rtl/spi_fl_line_fetch_if.sv
// Cache-side request port and flash-controller port of the line fetcher.
// The fetcher uses the slave modport; the cache/flash side uses master.
interface spi_fl_line_fetch_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic              c_valid;
  logic [ADDR_W-1:0] c_addr;
  logic [3:0]        c_wstrb;
  logic [DATA_W-1:0] c_rdata;
  logic              c_ready;
  logic              inv;
  logic              fl_valid;
  logic [31:0]       fl_addr;
  logic [DATA_W-1:0] fl_rdata;
  logic              fl_ready;

  modport master (
    output c_valid, c_addr, c_wstrb, inv, fl_rdata, fl_ready,
    input  c_rdata, c_ready, fl_valid, fl_addr
  );

  modport slave (
    input  c_valid, c_addr, c_wstrb, inv, fl_rdata, fl_ready,
    output c_rdata, c_ready, fl_valid, fl_addr
  );
endinterface

// File: rtl/spi_fl_line_fetch_linebuf.sv
// Line buffer: LINE_WORDS x DATA_W register file (one write, one async read)
// plus the tag/valid registers and the hit compare.
module spi_fl_linebuf
  import spi_fl_line_fetch_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 20,
  parameter int IDX_W      = idxWidth(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              tag_load_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [TAG_W-1:0]  lookup_tag_i,
  input  logic              valid_set_i,
  input  logic              valid_clr_i,
  output logic              hit_o
);

  logic [DATA_W-1:0] mem_q [LINE_WORDS];
  logic [TAG_W-1:0]  tag_q;
  logic              valid_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  // Clear beats set so an invalidate can never be lost to a completing fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (tag_load_i) tag_q <= tag_i;
      if (valid_clr_i)      valid_q <= 1'b0;
      else if (valid_set_i) valid_q <= 1'b1;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign hit_o     = valid_q && (tag_q == lookup_tag_i);

endmodule

// File: rtl/spi_fl_line_fetch.sv
// Read-line fetcher between the cache port and the SPI flash controller.
// Optional SPI_FL_EARLY_RESTART_EN: answer the critical word before the line completes.
module spi_fl_line_fetch
  import spi_fl_line_fetch_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input logic               clk,
  input logic               rst,
  spi_fl_line_fetch_if.slave bus
);

  localparam int IDX_W = idxWidth(LINE_WORDS);
  localparam int TAG_W = tagWidth(ADDR_W, LINE_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              inv_seen_q, inv_seen_d;
  logic              c_ready_q, c_ready_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic              fl_valid_q, fl_valid_d;
  logic [31:0]       fl_addr_q, fl_addr_d;
`ifdef SPI_FL_EARLY_RESTART_EN
  logic              resp_done_q, resp_done_d;
`endif

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic              req_new;
  logic              wr_en, tag_load, valid_set, valid_clr, hit;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        unused_addr_lsb;

  assign req_tag         = bus.c_addr[ADDR_W-1 -: TAG_W];
  assign req_idx         = bus.c_addr[IDX_W+1:2];
  assign unused_addr_lsb = bus.c_addr[1:0];
  // The cycle carrying c_ready still shows the old, held c_valid.
  assign req_new         = bus.c_valid && !c_ready_q;

`ifdef SPI_FL_EARLY_RESTART_EN
  assign rd_idx = (state_q == ST_IDLE || resp_done_q) ? req_idx : idx_q;
`else
  assign rd_idx = (state_q == ST_IDLE) ? req_idx : idx_q;
`endif

  spi_fl_linebuf #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W)
  ) u_linebuf (
    .clk          (clk),
    .rst          (rst),
    .wr_en_i      (wr_en),
    .wr_idx_i     (cnt_q),
    .wr_data_i    (bus.fl_rdata),
    .rd_idx_i     (rd_idx),
    .rd_data_o    (rd_data),
    .tag_load_i   (tag_load),
    .tag_i        (req_tag),
    .lookup_tag_i (req_tag),
    .valid_set_i  (valid_set),
    .valid_clr_i  (valid_clr),
    .hit_o        (hit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    tag_d      = tag_q;
    inv_seen_d = inv_seen_q;
    c_ready_d  = 1'b0;
    c_rdata_d  = c_rdata_q;
    fl_valid_d = 1'b0;
    fl_addr_d  = fl_addr_q;
    wr_en      = 1'b0;
    tag_load   = 1'b0;
    valid_set  = 1'b0;
    valid_clr  = 1'b0;
`ifdef SPI_FL_EARLY_RESTART_EN
    resp_done_d = resp_done_q;
`endif

    // An invalidate arriving mid-fill must leave the finished line invalid.
    if (state_q != ST_IDLE && bus.inv) inv_seen_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.inv) valid_clr = 1'b1;
        if (req_new) begin
          if (|bus.c_wstrb) begin
            c_ready_d = 1'b1;
            c_rdata_d = '0;
          end else if (hit && !bus.inv) begin
            c_ready_d = 1'b1;
            c_rdata_d = rd_data;
          end else begin
            tag_d      = req_tag;
            idx_d      = req_idx;
            cnt_d      = '0;
            inv_seen_d = 1'b0;
            tag_load   = 1'b1;
            valid_clr  = 1'b1;
            state_d    = ST_ISSUE;
`ifdef SPI_FL_EARLY_RESTART_EN
            resp_done_d = 1'b0;
`endif
          end
        end
      end
      ST_ISSUE: begin
        if (bus.fl_ready) begin
          fl_valid_d = 1'b1;
          fl_addr_d  = 32'({tag_q, cnt_q, 2'b00});
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!bus.fl_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.fl_ready) begin
          wr_en = 1'b1;
`ifdef SPI_FL_EARLY_RESTART_EN
          if (!resp_done_q && cnt_q == idx_q) begin
            c_ready_d   = 1'b1;
            c_rdata_d   = bus.fl_rdata;
            resp_done_d = 1'b1;
          end
`endif
          if (cnt_q == LAST_IDX) begin
            valid_set = !(inv_seen_q || bus.inv);
            state_d   = ST_RESP;
          end else begin
            cnt_d   = cnt_q + IDX_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
`ifdef SPI_FL_EARLY_RESTART_EN
        if (!resp_done_q) begin
          c_ready_d = 1'b1;
          c_rdata_d = rd_data;
        end
`else
        c_ready_d = 1'b1;
        c_rdata_d = rd_data;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef SPI_FL_EARLY_RESTART_EN
    // Background hit: same line, word already landed; everything else stalls.
    if (state_q != ST_IDLE && resp_done_q && req_new && !c_ready_d &&
        bus.c_wstrb == 4'd0 && !bus.inv && req_tag == tag_q && req_idx < cnt_q) begin
      c_ready_d = 1'b1;
      c_rdata_d = rd_data;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      tag_q      <= '0;
      inv_seen_q <= 1'b0;
      c_ready_q  <= 1'b0;
      c_rdata_q  <= '0;
      fl_valid_q <= 1'b0;
      fl_addr_q  <= '0;
`ifdef SPI_FL_EARLY_RESTART_EN
      resp_done_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      tag_q      <= tag_d;
      inv_seen_q <= inv_seen_d;
      c_ready_q  <= c_ready_d;
      c_rdata_q  <= c_rdata_d;
      fl_valid_q <= fl_valid_d;
      fl_addr_q  <= fl_addr_d;
`ifdef SPI_FL_EARLY_RESTART_EN
      resp_done_q <= resp_done_d;
`endif
    end
  end

  assign bus.c_ready  = c_ready_q;
  assign bus.c_rdata  = c_rdata_q;
  assign bus.fl_valid = fl_valid_q;
  assign bus.fl_addr  = fl_addr_q;

endmodule

// File: tb/tb_spi_fl_line_fetch.sv
// Directed bench for spi_fl_line_fetch with a 4-cycle flash controller model
// that returns 0xA0 + word-in-line for every read.
module tb_spi_fl_line_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;
  int flPulses = 0;
  int readyCount = 0;
  int flBusy = 0;
  logic [31:0] flAddrLog[$];

  spi_fl_line_fetch_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  spi_fl_line_fetch #(.ADDR_W(24), .DATA_W(32), .LINE_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Flash controller model: drops ready after a launch, returns data 4 cycles later.
  always @(negedge clk) begin
    if (rst) begin
      flBusy       = 0;
      bus.fl_ready = 1'b1;
    end else begin
      if (bus.c_ready) readyCount++;
      if (flBusy > 0) begin
        flBusy--;
        if (flBusy == 0) bus.fl_ready = 1'b1;
      end
      if (bus.fl_valid) begin
        flPulses++;
        flAddrLog.push_back(bus.fl_addr);
        bus.fl_rdata = 32'hA0 + {28'd0, bus.fl_addr[3:2]};
        bus.fl_ready = 1'b0;
        flBusy       = 4;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One cache request, held until c_ready; then idle long enough for any fill to drain.
  task automatic applyStimulus(input logic [23:0] addr, input logic [3:0] wstrb,
                               input bit pulseInv, output logic [31:0] rdata,
                               output int latency);
    bit got;
    got     = 1'b0;
    latency = 0;
    rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.c_valid = 1'b1;
    bus.c_addr  = addr;
    bus.c_wstrb = wstrb;
    bus.inv     = pulseInv;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      bus.inv = 1'b0;
      latency++;
      if (bus.c_ready) begin
        got   = 1'b1;
        rdata = bus.c_rdata;
      end
    end
    bus.c_valid = 1'b0;
    bus.c_wstrb = 4'd0;
    checkOutput("ready_seen", {31'd0, got}, 32'd1);
    repeat (30) @(negedge clk);
  endtask

  task automatic startWindow();
    flPulses   = 0;
    readyCount = 0;
    flAddrLog.delete();
  endtask

  function automatic logic [31:0] logAt(input int i);
    return (i < flAddrLog.size()) ? flAddrLog[i] : 32'hFFFF_FFFF;
  endfunction

  logic [31:0] rdata;
  int latency;
  bit seen;

  initial begin
    bus.c_valid  = 1'b0;
    bus.c_addr   = '0;
    bus.c_wstrb  = 4'd0;
    bus.inv      = 1'b0;
    bus.fl_ready = 1'b1;
    bus.fl_rdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_c_ready", {31'd0, bus.c_ready}, 32'd0);
    checkOutput("rst_c_rdata", bus.c_rdata, 32'd0);
    checkOutput("rst_fl_valid", {31'd0, bus.fl_valid}, 32'd0);
    checkOutput("rst_fl_addr", bus.fl_addr, 32'd0);
    rst = 1'b0;

    startWindow();
    applyStimulus(24'h000104, 4'd0, 1'b0, rdata, latency);
    checkOutput("miss_rdata", rdata, 32'hA1);
    checkOutput("miss_pulses", flPulses, 4);
    checkOutput("miss_ready_cnt", readyCount, 1);
    checkOutput("miss_addr0", logAt(0), 32'h100);
    checkOutput("miss_addr1", logAt(1), 32'h104);
    checkOutput("miss_addr2", logAt(2), 32'h108);
    checkOutput("miss_addr3", logAt(3), 32'h10C);

    startWindow();
    applyStimulus(24'h00010C, 4'd0, 1'b0, rdata, latency);
    checkOutput("hit_rdata", rdata, 32'hA3);
    checkOutput("hit_latency", latency, 1);
    checkOutput("hit_pulses", flPulses, 0);

    startWindow();
    applyStimulus(24'h000200, 4'd0, 1'b0, rdata, latency);
    checkOutput("line200_rdata", rdata, 32'hA0);
    checkOutput("line200_pulses", flPulses, 4);
    checkOutput("line200_addr0", logAt(0), 32'h200);
    startWindow();
    applyStimulus(24'h000104, 4'd0, 1'b0, rdata, latency);
    checkOutput("refetch_rdata", rdata, 32'hA1);
    checkOutput("refetch_pulses", flPulses, 4);
    checkOutput("refetch_addr0", logAt(0), 32'h100);

    startWindow();
    applyStimulus(24'h000100, 4'd0, 1'b1, rdata, latency);
    checkOutput("inv_rdata", rdata, 32'hA0);
    checkOutput("inv_pulses", flPulses, 4);

    startWindow();
    applyStimulus(24'h000100, 4'hF, 1'b0, rdata, latency);
    checkOutput("write_rdata", rdata, 32'd0);
    checkOutput("write_latency", latency, 1);
    checkOutput("write_pulses", flPulses, 0);
    startWindow();
    applyStimulus(24'h000108, 4'd0, 1'b0, rdata, latency);
    checkOutput("after_write_rdata", rdata, 32'hA2);
    checkOutput("after_write_latency", latency, 1);
    checkOutput("after_write_pulses", flPulses, 0);

    // Reset in the middle of word 1's flash transaction.
    startWindow();
    @(negedge clk);
    bus.inv = 1'b1;
    @(negedge clk);
    bus.inv     = 1'b0;
    bus.c_valid = 1'b1;
    bus.c_addr  = 24'h000104;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.fl_valid && bus.fl_addr == 32'h104) seen = 1'b1;
    end
    checkOutput("rst_word1_launch", {31'd0, seen}, 32'd1);
    repeat (2) @(negedge clk);
    rst         = 1'b1;
    bus.c_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_c_ready", {31'd0, bus.c_ready}, 32'd0);
    checkOutput("midrst_c_rdata", bus.c_rdata, 32'd0);
    checkOutput("midrst_fl_valid", {31'd0, bus.fl_valid}, 32'd0);
    checkOutput("midrst_fl_addr", bus.fl_addr, 32'd0);
    checkOutput("midrst_no_resp", readyCount, 0);
    rst = 1'b0;
    startWindow();
    applyStimulus(24'h000104, 4'd0, 1'b0, rdata, latency);
    checkOutput("postrst_rdata", rdata, 32'hA1);
    checkOutput("postrst_pulses", flPulses, 4);
    checkOutput("postrst_addr0", logAt(0), 32'h100);
    checkOutput("postrst_addr3", logAt(3), 32'h10C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
